nios_system_to_sw_mailbox: RTL
==============================

NIOS_SYSTEM_TO_SW_MAILBOX -- requirements
Module: nios_system_to_sw_mailbox

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of FIFO entries (power of 2, 2..16).
REQ-002 SHALL have port clk input 1 as the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n input 1: asynchronous, active-low reset.
REQ-004 SHALL have port address input 2, register select.
REQ-005 SHALL have port chipselect input 1, bus access qualifier.
REQ-006 SHALL have port write_n input 1, active-low write strobe, valid only with chipselect.
REQ-007 SHALL have port writedata input 32, bus write data.
REQ-008 SHALL have port readdata output 32, registered bus read data.
REQ-009 SHALL have port hw_data input 32, word offered by hardware.
REQ-010 SHALL have port hw_valid input 1, hardware offers hw_data.
REQ-011 SHALL have port hw_ready output 1, mailbox accepts the word this cycle.
REQ-012 SHALL have port irq output 1, level interrupt to the processor.

Function
REQ-013 SHALL buffer hardware words in a DEPTH-entry FIFO with read pointer, write pointer and count (0..DEPTH).
REQ-014 SHALL drive hw_ready = (count != DEPTH), combinationally from registered count.
REQ-015 SHALL push hw_data when hw_valid && hw_ready; the pushed word becomes visible at the next edge.
REQ-016 SHALL set sticky overflow on hw_valid && !hw_ready and drop that word; FIFO contents unchanged.
REQ-017 SHALL use register map: 0 DATA (RO, head word, 0 when empty); 1 STATUS (RO); 2 CONTROL (RW); 3 POP (WO).
REQ-018 SHALL define STATUS bits: [0] empty, [1] full, [2] overflow, [7:3] count, [31:8] zero.
REQ-019 SHALL define CONTROL bits: [0] irq_en (R/W); bit [1] written 1 clears overflow (self-clearing, reads 0); [31:2] read 0.
REQ-020 SHALL pop one entry on any write to address 3 (data ignored); pop when empty is ignored with no pointer change.
REQ-021 SHALL treat reads as side-effect free; only POP writes remove data.
REQ-022 SHALL update readdata every clock from the addressed register, regardless of chipselect, giving 1-cycle read latency.
REQ-023 SHALL, on push and pop in the same cycle with count in 1..DEPTH-1, advance both pointers and keep count unchanged.
REQ-024 SHALL, with count == DEPTH, refuse the push (hw_ready low) even when a pop occurs that cycle; the pop completes and count becomes DEPTH-1.
REQ-025 SHALL, with count == 0, make a same-cycle push and pop equivalent to the push only.
REQ-026 SHALL wrap pointers modulo DEPTH.
REQ-027 SHALL, when overflow set and clear occur in the same cycle, leave overflow set.
REQ-028 SHALL drive irq = irq_en && (!empty || overflow), from registered state.
REQ-029 SHALL ignore writes to addresses 0 and 1.

Reset
REQ-030 SHALL, while reset_n is low, asynchronously clear pointers, count, overflow, irq_en and readdata to 0; hw_ready = 1 and irq = 0.
REQ-031 SHALL not clear FIFO storage on reset; storage contents are undefined and unobservable, since DATA reads 0 when empty.
REQ-032 SHALL, on reset asserted mid-operation, discard all queued words; the first push after release lands at entry 0.

Verification
REQ-033 SHALL pass this scenario: push 0xA5A5_0001 and then read address 0 -> readdata is 0xA5A5_0001 one cycle after the address is presented; STATUS = 0x0000_0008.
REQ-034 SHALL pass this scenario: push 5 words with DEPTH=4 -> hw_ready is low after the 4th push, overflow is set, and STATUS = 0x0000_0026; 4 POPs return words 1-4 in order.
REQ-035 SHALL pass this scenario: with count=2, a push and a POP in the same cycle -> count stays 2 and the head advances to the next word.
REQ-036 SHALL pass this scenario: with count=4 and hw_valid held, a POP -> count becomes 3 that cycle and the next cycle accepts the held word (count=4).
REQ-037 SHALL pass this scenario: write CONTROL=1 with the FIFO empty -> irq=0; one push -> irq=1 next cycle; POP -> irq=0; overflow then CONTROL=3 -> overflow clears and irq_en stays 1.
REQ-038 SHALL pass this scenario: reset_n pulsed low with count=3 -> STATUS reads 0x0000_0001, DATA reads 0, and irq=0 immediately.

Source files
------------

// File: rtl/nios_system_to_sw_mailbox.sv
// Hardware-to-software mailbox: hardware pushes 32-bit words into a small
// FIFO, and the processor reads and pops them through a 4-register bus slave.
// A level interrupt is raised while words are waiting or a word was dropped.
module nios_system_to_sw_mailbox #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [31:0] hw_data,
  input  logic        hw_valid,
  output logic        hw_ready,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_POP     = 2'd3;

  typedef logic [AW-1:0] ptr_t;

  logic [31:0] mem_q [DEPTH];
  ptr_t        rdPtr_q, rdPtr_d;
  ptr_t        wrPtr_q, wrPtr_d;
  logic [4:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        irqEn_q, irqEn_d;
  logic [31:0] readdata_q, readdata_d;

  logic        busWrite;
  logic        popReq;
  logic        pushFire;
  logic        popFire;
  logic        fifoEmpty;
  logic        fifoFull;
  logic        ctrlWrite;
  logic        overflowClr;
  logic [31:0] headWord;
  logic [31:0] statusWord;
  logic        unusedWriteBits;

  // Only bits [1:0] of writedata carry meaning; the rest are intentionally ignored.
  assign unusedWriteBits = ^writedata[31:2];

  // Occupancy flags, handshake and bus decode, all derived from registered state.
  assign fifoEmpty   = (count_q == 5'd0);
  assign fifoFull    = (count_q == 5'(DEPTH));
  assign hw_ready    = !fifoFull;
  assign busWrite    = chipselect && !write_n;
  assign popReq      = busWrite && (address == ADDR_POP);
  assign ctrlWrite   = busWrite && (address == ADDR_CONTROL);
  assign overflowClr = ctrlWrite && writedata[1];
  assign pushFire    = hw_valid && hw_ready;
  assign popFire     = popReq && !fifoEmpty;
  assign headWord    = fifoEmpty ? 32'd0 : mem_q[rdPtr_q];
  assign statusWord  = {24'd0, count_q, overflow_q, fifoFull, fifoEmpty};
  assign readdata    = readdata_q;
  assign irq         = irqEn_q && (!fifoEmpty || overflow_q);

  // Next-state logic for pointers, count, sticky overflow, irq enable and read data.
  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irqEn_d    = irqEn_q;
    readdata_d = 32'd0;

    if (pushFire) begin
      wrPtr_d = wrPtr_q + ptr_t'(1);
    end
    if (popFire) begin
      rdPtr_d = rdPtr_q + ptr_t'(1);
    end

    unique case ({pushFire, popFire})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // A dropped word in the same cycle as a clear wins, so no drop goes unseen.
    if (hw_valid && !hw_ready) begin
      overflow_d = 1'b1;
    end else if (overflowClr) begin
      overflow_d = 1'b0;
    end

    if (ctrlWrite) begin
      irqEn_d = writedata[0];
    end

    unique case (address)
      ADDR_DATA:    readdata_d = headWord;
      ADDR_STATUS:  readdata_d = statusWord;
      ADDR_CONTROL: readdata_d = {31'd0, irqEn_q};
      default:      readdata_d = 32'd0;
    endcase
  end

  // Control state registers, cleared asynchronously so queued words are discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= 5'd0;
      overflow_q <= 1'b0;
      irqEn_q    <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irqEn_q    <= irqEn_d;
      readdata_q <= readdata_d;
    end
  end

  // FIFO storage has no reset; stale entries are never visible since DATA reads 0 when empty.
  always_ff @(posedge clk) begin
    if (pushFire) begin
      mem_q[wrPtr_q] <= hw_data;
    end
  end

endmodule
